// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - decoupled instruction prefetch unit with a DEPTH-entry PC/instruction FIFO
// Optional IF_MISALIGN_CHECK_EN: a misaligned redirect raises misalign_o and halts fetch until an aligned redirect.
module if_prefetch #(
   parameter int                  XLEN     = 32,
   parameter int                  PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
   parameter int                  DEPTH    = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                redirect_i,
   input  logic [PC_WIDTH-1:0] redirect_pc_i,
   output logic                imem_req_o,
   output logic [PC_WIDTH-1:0] imem_addr_o,
   input  logic                imem_gnt_i,
   input  logic                imem_rvalid_i,
   input  logic [XLEN-1:0]     imem_rdata_i,
   output logic                inst_valid_o,
   input  logic                inst_ready_i,
   output logic [XLEN-1:0]     inst_o,
   output logic [PC_WIDTH-1:0] pc_o,
   output logic [PC_WIDTH-1:0] pcplus4_o,
   output logic                misalign_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
   logic [CW-1:0]       outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d, count_q, count_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [XLEN-1:0]     inst_mem_q [DEPTH];
   logic [PC_WIDTH-1:0] pc_mem_q [DEPTH];
   logic [PC_WIDTH-1:0] target;
   logic [CW:0]         credit_used;
   logic                grant, push, pop, halt_q;

`ifdef IF_MISALIGN_CHECK_EN
   logic halt_d, target_misaligned;

   assign target            = redirect_pc_i;
   assign target_misaligned = (redirect_pc_i[1:0] != 2'b00);
   assign halt_d            = redirect_i ? target_misaligned : halt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) halt_q <= 1'b0;
      else        halt_q <= halt_d;
   end
   assign misalign_o = halt_q;
`else
   logic unused_low_bits;

   assign unused_low_bits = ^redirect_pc_i[1:0];
   assign target          = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
   assign halt_q          = 1'b0;
   assign misalign_o      = 1'b0;
`endif

   // Credit counts requests in flight plus buffered entries, so a granted response always has a slot.
   assign credit_used  = {1'b0, outstanding_q} + {1'b0, count_q};
   assign imem_req_o   = rst_n && !redirect_i && !halt_q && (credit_used < (CW+1)'(DEPTH));
   assign imem_addr_o  = fetch_pc_q;
   assign grant        = imem_req_o && imem_gnt_i;
   assign inst_valid_o = (count_q != '0);
   assign pop          = inst_valid_o && inst_ready_i && !redirect_i;
   assign push         = imem_rvalid_i && (drop_cnt_q == '0) && !redirect_i;
   assign inst_o       = inst_mem_q[rd_ptr_q];
   assign pc_o         = pc_mem_q[rd_ptr_q];
   assign pcplus4_o    = pc_o + PC_WIDTH'(4);

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding_q;
      drop_cnt_d    = drop_cnt_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      if (grant) fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
      case ({grant, imem_rvalid_i})
         2'b10:   outstanding_d = outstanding_q + CW'(1);
         2'b01:   outstanding_d = outstanding_q - CW'(1);
         default: outstanding_d = outstanding_q;
      endcase
      if (redirect_i) begin
         // Every request still in flight belongs to the old path; the one answering now is already gone.
         fetch_pc_d = target;
         resp_pc_d  = target;
         drop_cnt_d = outstanding_q - CW'(imem_rvalid_i);
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         if (imem_rvalid_i && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
         if (push) begin
            resp_pc_d = resp_pc_q + PC_WIDTH'(4);
            wr_ptr_d  = wr_ptr_q + AW'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem_q[wr_ptr_q] <= imem_rdata_i;
         pc_mem_q[wr_ptr_q]   <= resp_pc_q;
      end
   end
endmodule

// File: tb/tb_if_prefetch.sv
// tb/tb_if_prefetch.sv - randomized bench for if_prefetch against a queue-based fetch/memory model
// Honours IF_MISALIGN_CHECK_EN when defined for the build.
module tb_if_prefetch;
   localparam int          XLEN     = 32;
   localparam int          PW       = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            redirect_i = 1'b0;
   logic [PW-1:0]   redirect_pc_i = '0;
   logic            imem_req_o;
   logic [PW-1:0]   imem_addr_o;
   logic            imem_gnt_i = 1'b0;
   logic            imem_rvalid_i = 1'b0;
   logic [XLEN-1:0] imem_rdata_i = '0;
   logic            inst_valid_o;
   logic            inst_ready_i = 1'b0;
   logic [XLEN-1:0] inst_o;
   logic [PW-1:0]   pc_o;
   logic [PW-1:0]   pcplus4_o;
   logic            misalign_o;

   if_prefetch #(.XLEN(XLEN), .PC_WIDTH(PW), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .inst_valid_o(inst_valid_o),
      .inst_ready_i(inst_ready_i), .inst_o(inst_o), .pc_o(pc_o), .pcplus4_o(pcplus4_o),
      .misalign_o(misalign_o)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int due; bit live; } req_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

   req_t        inflight[$];
   ent_t        fifo[$];
   logic [31:0] m_fetch_pc;
   bit          m_halt;
   int          cyc, last_due, n_chk, n_fail, lat_lo, lat_hi;
   bit          gnt, rdy, redir, found;
   logic [31:0] redir_pc;
   logic [31:0] gnt_log[$], pc_log[$], inst_log[$];

   function automatic logic [31:0] mem_data(logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 32'hDEAD_DEAD;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      redirect_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; inst_ready_i = 1'b0;
      redir = 1'b0; gnt = 1'b0; rdy = 1'b0;
      #1;
      chk("rst_req", imem_req_o, 1'b0);
      chk("rst_valid", inst_valid_o, 1'b0);
      chk("rst_misalign", misalign_o, 1'b0);
      inflight.delete(); fifo.delete();
      m_fetch_pc = RESET_PC; m_halt = 1'b0; last_due = 0;
      gnt_log.delete(); pc_log.delete(); inst_log.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // One cycle: drive, compare mid-cycle against the model, then advance the model.
   task automatic step();
      bit          rv, exp_req, pop;
      logic [31:0] tgt;
      req_t        r;
      ent_t        e;
      int          due;
      rv = (inflight.size() > 0) && (inflight[0].due <= cyc);
      redirect_i    = redir;
      redirect_pc_i = redir_pc;
      inst_ready_i  = rdy;
      imem_gnt_i    = gnt;
      imem_rvalid_i = rv;
      imem_rdata_i  = rv ? mem_data(inflight[0].addr) : $urandom();
      #4;
      exp_req = !redir && !m_halt && (inflight.size() + fifo.size() < DEPTH);
      chk("imem_req", imem_req_o, exp_req);
      if (exp_req) chk("imem_addr", imem_addr_o, m_fetch_pc);
      chk("inst_valid", inst_valid_o, fifo.size() > 0);
      if (fifo.size() > 0) begin
         chk("inst", inst_o, fifo[0].inst);
         chk("pc", pc_o, fifo[0].pc);
         chk("pcplus4", pcplus4_o, fifo[0].pc + 32'd4);
      end
      chk("misalign", misalign_o, m_halt);
      if (imem_req_o && gnt) gnt_log.push_back(imem_addr_o);
      if (inst_valid_o && rdy && !redir) begin
         pc_log.push_back(pc_o);
         inst_log.push_back(inst_o);
      end
      pop = (fifo.size() > 0) && rdy;
      if (redir) begin
         tgt = redir_pc;
`ifndef IF_MISALIGN_CHECK_EN
         tgt[1:0] = 2'b00;
`endif
         foreach (inflight[i]) inflight[i].live = 1'b0;
         if (rv) r = inflight.pop_front();
         fifo.delete();
         m_fetch_pc = tgt;
`ifdef IF_MISALIGN_CHECK_EN
         m_halt = (tgt[1:0] != 2'b00);
`endif
      end else begin
         if (pop) e = fifo.pop_front();
         if (rv) begin
            r = inflight.pop_front();
            if (r.live) begin
               chk("fifo_has_room", fifo.size() < DEPTH, 1'b1);
               e.pc = r.addr;
               e.inst = mem_data(r.addr);
               fifo.push_back(e);
            end
         end
         if (exp_req && gnt) begin
            due = cyc + $urandom_range(lat_hi, lat_lo);
            if (due <= last_due) due = last_due + 1;
            r.addr = m_fetch_pc; r.due = due; r.live = 1'b1;
            last_due = due;
            inflight.push_back(r);
            m_fetch_pc = m_fetch_pc + 32'd4;
         end
      end
      @(posedge clk);
      #1 cyc++;
   endtask

   initial begin
      n_chk = 0; n_fail = 0; cyc = 0; redir_pc = '0; lat_lo = 1; lat_hi = 1;
      @(posedge clk);
      #1;

      // Streaming with single-cycle memory.
      do_reset();
      gnt = 1; rdy = 1; lat_lo = 1; lat_hi = 1;
      repeat (8) step();
      chk("p1_grants", gnt_log.size(), 8);
      chk("p1_addr0", at(gnt_log, 0), 32'h0);
      chk("p1_addr1", at(gnt_log, 1), 32'h4);
      chk("p1_addr2", at(gnt_log, 2), 32'h8);
      chk("p1_pc0", at(pc_log, 0), 32'h0);
      chk("p1_pc1", at(pc_log, 1), 32'h4);
      chk("p1_pc2", at(pc_log, 2), 32'h8);
      chk("p1_inst0", at(inst_log, 0), 32'h1357_9BDF);

      // Decode stalled: credits stop at DEPTH.
      do_reset();
      gnt = 1; rdy = 0;
      repeat (12) step();
      chk("p2_grants", gnt_log.size(), 4);
      chk("p2_last", at(gnt_log, 3), 32'hC);
      rdy = 1;
      repeat (4) step();
      chk("p2_resume", at(gnt_log, 4), 32'h10);

      // Redirect with three slow requests in flight.
      do_reset();
      gnt = 1; rdy = 1; lat_lo = 6; lat_hi = 6;
      repeat (3) step();
      gnt = 0; redir = 1; redir_pc = 32'h100;
      step();
      redir = 0;
      chk("p3_flushed", inst_valid_o, 1'b0);
      pc_log.delete();
      gnt = 1; lat_lo = 1; lat_hi = 3;
      repeat (20) step();
      chk("p3_first_pc", at(pc_log, 0), 32'h100);

      // Redirect coinciding with a response and a pop.
      do_reset();
      gnt = 1; rdy = 1; lat_lo = 2; lat_hi = 2; found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (inflight.size() > 0 && inflight[0].due <= cyc && fifo.size() > 0) found = 1;
         else step();
      end
      chk("p4_setup", found, 1'b1);
      redir = 1; redir_pc = 32'h300;
      step();
      redir = 0;
      pc_log.delete();
      repeat (15) step();
      chk("p4_first_pc", at(pc_log, 0), 32'h300);

      // Grant withheld: address must hold.
      do_reset();
      gnt = 0; rdy = 1; lat_lo = 1; lat_hi = 1;
      repeat (5) step();
      chk("p5_no_grant", gnt_log.size(), 0);
      chk("p5_hold_addr", imem_addr_o, 32'h0);
      gnt = 1;
      step();
      gnt = 0;
      repeat (3) step();
      chk("p5_one_grant", gnt_log.size(), 1);
      chk("p5_granted", at(gnt_log, 0), 32'h0);
      chk("p5_advance", imem_addr_o, 32'h4);

`ifdef IF_MISALIGN_CHECK_EN
      do_reset();
      gnt = 1; rdy = 1;
      repeat (4) step();
      redir = 1; redir_pc = 32'h102;
      step();
      redir = 0; redirect_i = 1'b0;
      #1;
      chk("p6_misalign_set", misalign_o, 1'b1);
      chk("p6_halt_req", imem_req_o, 1'b0);
      repeat (5) step();
      redir = 1; redir_pc = 32'h200;
      step();
      redir = 0;
      gnt_log.delete();
      repeat (3) step();
      chk("p6_misalign_clr", misalign_o, 1'b0);
      chk("p6_resume", at(gnt_log, 0), 32'h200);
`else
      do_reset();
      gnt = 1; rdy = 1;
      redir = 1; redir_pc = 32'h102;
      step();
      redir = 0;
      repeat (3) step();
      chk("p6_aligned_target", at(gnt_log, 0), 32'h100);
      chk("p6_misalign_tied", misalign_o, 1'b0);
`endif

      // Randomized traffic with one asynchronous reset in the middle.
      do_reset();
      lat_lo = 1; lat_hi = 4;
      for (int k = 0; k < 3000; k++) begin
         if (k == 1500) do_reset();
         gnt   = ($urandom_range(3, 0) != 0);
         rdy   = ($urandom_range(3, 0) != 0);
         redir = ($urandom_range(19, 0) == 0);
         redir_pc = {20'h0, 10'($urandom_range(1023, 0)), 2'b00};
         if ($urandom_range(7, 0) == 0) redir_pc[1:0] = 2'($urandom_range(3, 1));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
